instr_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 16-bit, 4-register datapath. It fetches instructions over an imem req/ack handshake and holds them in an instruction register (IR) that feeds the instruction decoder. It then steps the datapath through DECODE, EXEC, MEM and WB. It issues single-cycle write strobes, so register-file and data-memory writes happen exactly once per instruction. It also owns the PC, the jump and halt opcodes, and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle 16-bit CPU: FSM state encoding,
// opcode constants and instruction width.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;

  // Encoding is visible on state_out, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_CMP0  = 4'b1011;
  localparam logic [3:0] OP_CMP1  = 4'b1100;
  localparam logic [3:0] OP_JMP   = 4'b1110;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 16-bit, 4-register datapath.
// Fetches over an imem req/ack handshake into the IR, then walks
// DECODE -> EXEC -> [MEM] -> [WB]. Owns PC, JMP/HLT handling and the
// retired-instruction counter. All reqs/strobes are Moore outputs.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             level; leaves IDLE when high
//   imem_req/addr/ack instruction fetch handshake, instr_in fetched word
//   ir_out            latched instruction to the external decoder
//   dec_regwrite/memwrite/memtoreg  decoder controls for ir_out
//   dmem_req/we/ack   data memory handshake
//   rf_we             single-cycle register-file write strobe
//   pc_out, state_out, halted, retired  status
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] ir_out,
  input  logic               dec_regwrite,
  input  logic               dec_memwrite,
  input  logic               dec_memtoreg,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               rf_we,
  output logic [PC_W-1:0]    pc_out,
  output logic [2:0]         state_out,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic [7:0]         jmp_field;
  logic [PC_W-1:0]    jmp_target;
  logic [3:0]         opcode;

  assign opcode    = opcode_of(ir_q);
  assign jmp_field = ir_q[7:0];
  // Jump target field is 8 bits; zero-extended (or truncated) to the PC width.
  assign jmp_target = PC_W'(jmp_field);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d    = instr_in;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opcode == OP_HLT) begin
          state_d = StHalt;
        end else if (opcode == OP_JMP) begin
          pc_d    = jmp_target;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (dec_memwrite || dec_memtoreg) begin
          state_d = StMem;
        end else if (dec_regwrite) begin
          state_d = StWb;
        end else begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StMem: begin
        if (dmem_ack) begin
          if (dec_memtoreg) begin
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == StMem);
  assign dmem_we   = (state_q == StMem) && dec_memwrite;
  assign rf_we     = (state_q == StWb);
  assign halted    = (state_q == StHalt);
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign state_out = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] instr_in;
  logic [15:0] ir_out;
  logic        dec_regwrite;
  logic        dec_memwrite;
  logic        dec_memtoreg;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [7:0]  pc_out;
  logic [2:0]  state_out;
  logic        halted;
  logic [15:0] retired;

  instr_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_in     (instr_in),
    .ir_out       (ir_out),
    .dec_regwrite (dec_regwrite),
    .dec_memwrite (dec_memwrite),
    .dec_memtoreg (dec_memtoreg),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .rf_we        (rf_we),
    .pc_out       (pc_out),
    .state_out    (state_out),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External decoder model.
  logic [3:0] dop;
  assign dop          = ir_out[15:12];
  assign dec_memtoreg = (dop == 4'h0);
  assign dec_memwrite = (dop == 4'h1);
  assign dec_regwrite = !(dop inside {4'h1, 4'hB, 4'hC, 4'hE, 4'hF});

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  logic [15:0] imem [256];
  int  imem_dly = 0;
  int  dmem_dly = 0;
  bit  rnd_mode = 0;
  int  obs_rf, obs_dw, obs_dr;

  // Responder and reference-model state.
  bit         i_pend, d_pend;
  int         i_cnt, i_dly, d_cnt, d_dly;
  logic [7:0] m_pc;
  int         m_ret;
  int         exp_rf, exp_dmem;
  bit         m_halt, m_halt_seen;
  logic [3:0] mop;

  initial begin
    imem_ack = 0; dmem_ack = 0; instr_in = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack = 0; dmem_ack = 0; i_pend = 0; d_pend = 0;
      m_pc = 0; m_ret = 0; exp_rf = 0; exp_dmem = 0; m_halt = 0; m_halt_seen = 0;
    end else begin
      if (imem_req) begin
        if (!i_pend) begin
          i_pend = 1; i_cnt = 0;
          i_dly = rnd_mode ? int'($urandom_range(0, 3)) : imem_dly;
        end
        if (i_cnt >= i_dly) begin
          imem_ack = 1; i_pend = 0; instr_in = imem[imem_addr];
        end else begin
          imem_ack = 0; i_cnt++;
        end
      end else begin
        i_pend = 0;
        imem_ack = rnd_mode && ($urandom_range(0, 3) == 0);
        instr_in = 16'($urandom);
      end
      if (dmem_req) begin
        if (!d_pend) begin
          d_pend = 1; d_cnt = 0;
          d_dly = rnd_mode ? int'($urandom_range(0, 3)) : dmem_dly;
        end
        if (d_cnt >= d_dly) begin
          dmem_ack = 1; d_pend = 0;
        end else begin
          dmem_ack = 0; d_cnt++;
        end
      end else begin
        d_pend = 0;
        dmem_ack = rnd_mode && ($urandom_range(0, 3) == 0);
      end

      // Monitor against the instruction-level model.
      if (rf_we) begin
        obs_rf++;
        chk("rf_we_expected", exp_rf > 0, 1);
        if (exp_rf > 0) exp_rf--;
      end
      if (dmem_req && dmem_ack) begin
        if (dmem_we) obs_dw++;
        else obs_dr++;
        chk("dmem_expected", exp_dmem != 0, 1);
        chk("dmem_we_kind", dmem_we, exp_dmem == 2);
        exp_dmem = 0;
      end
      if (imem_req && imem_ack) begin
        chk("prev_insn_done", (exp_rf == 0) && (exp_dmem == 0), 1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("retired_at_fetch", retired, 16'(m_ret));
        mop  = instr_in[15:12];
        m_pc = m_pc + 8'd1;
        case (mop)
          4'hF: m_halt = 1;
          4'hE: begin m_pc = instr_in[7:0]; m_ret++; end
          4'h0: begin exp_dmem = 1; exp_rf = 1; m_ret++; end
          4'h1: begin exp_dmem = 2; m_ret++; end
          4'hB, 4'hC: m_ret++;
          default: begin exp_rf = 1; m_ret++; end
        endcase
      end
      if (halted && !m_halt_seen) begin
        m_halt_seen = 1;
        chk("halt_expected", m_halt, 1);
        chk("retired_at_halt", retired, 16'(m_ret));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic fill_hlt();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  typedef struct {
    logic [15:0] instr;
    int id;   // imem wait cycles
    int dd;   // dmem wait cycles
    int cyc;  // cycles from first FETCH to HALT (instruction + HLT fetch/decode)
    int rf;
    int dw;
    int dr;
    int pc;
    int ret;
  } vec_t;

  vec_t vt[9];

  initial begin
    rst_n = 0; start = 0;
    fill_hlt();
    // instruction cycles N; total = N + id + 2 for the trailing HLT.
    vt[0] = '{16'h21C0, 0, 0, 4 + 2,         1, 0, 0, 2, 1};  // ALU
    vt[1] = '{16'h0123, 0, 2, 5 + 2 + 2,     1, 0, 1, 2, 1};  // load, 3-cycle MEM
    vt[2] = '{16'h1045, 1, 1, 4 + 2 + 1 + 2, 0, 1, 0, 2, 1};  // store
    vt[3] = '{16'hB012, 0, 0, 3 + 2,         0, 0, 0, 2, 1};  // compare
    vt[4] = '{16'hC000, 2, 0, 3 + 2 + 2 + 2, 0, 0, 0, 2, 1};  // compare, slow fetch
    vt[5] = '{16'hE003, 0, 0, 2 + 2,         0, 0, 0, 4, 1};  // JMP to 3
    vt[6] = '{16'h5A5A, 3, 0, 4 + 3 + 3 + 2, 1, 0, 0, 2, 1};  // ALU, slow fetch
    vt[7] = '{16'hF000, 0, 0, 2,             0, 0, 0, 1, 0};  // HLT only
    vt[8] = '{16'h0777, 1, 0, 5 + 1 + 1 + 2, 1, 0, 1, 2, 1};  // load, slow fetch

    // Reset / idle.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      chk("idle_state", state_out, 3'd0);
      chk("idle_strobes", {imem_req, dmem_req, dmem_we, rf_we, halted}, 5'b0);
      chk("idle_pc_ret", {pc_out, retired}, 24'h0);
      step();
    end

    // Table of single-instruction programs.
    for (int v = 0; v < 9; v++) begin
      int cyc;
      fill_hlt();
      imem[0] = vt[v].instr;
      if (vt[v].instr == 16'hE003) imem[3] = 16'hF000;
      imem_dly = vt[v].id; dmem_dly = vt[v].dd;
      do_reset();
      obs_rf = 0; obs_dw = 0; obs_dr = 0;
      pulse_start();
      cyc = 0;
      while (!halted && cyc < 200) begin step(); cyc++; end
      chk($sformatf("vec%0d_halted", v), halted, 1);
      chk($sformatf("vec%0d_cycles", v), cyc, vt[v].cyc);
      chk($sformatf("vec%0d_rf_we", v), obs_rf, vt[v].rf);
      chk($sformatf("vec%0d_dmem_wr", v), obs_dw, vt[v].dw);
      chk($sformatf("vec%0d_dmem_rd", v), obs_dr, vt[v].dr);
      chk($sformatf("vec%0d_pc", v), pc_out, vt[v].pc);
      chk($sformatf("vec%0d_retired", v), retired, vt[v].ret);
    end

    // ADD timing: req in cycle 1, rf_we only in cycle 4.
    fill_hlt(); imem[0] = 16'h21C0; imem_dly = 0; dmem_dly = 0;
    do_reset();
    pulse_start();
    chk("add_req_c1", imem_req, 1);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("add_rf_we_c%0d", c), rf_we, c == 4);
      step();
    end
    chk("add_pc", pc_out, 8'd1);
    chk("add_retired", retired, 16'd1);

    // Store then compare: 7 cycles, one write, no rf_we.
    fill_hlt(); imem[0] = 16'h1000; imem[1] = 16'hB000;
    do_reset();
    obs_rf = 0; obs_dw = 0; obs_dr = 0;
    pulse_start();
    repeat (7) step();
    chk("stcmp_retired", retired, 16'd2);
    chk("stcmp_rf_we", obs_rf, 0);
    chk("stcmp_dmem_wr", obs_dw, 1);

    // JMP with PC wrap, then halt.
    fill_hlt(); imem[0] = 16'hE0FF; imem[255] = 16'hE005; imem[5] = 16'hF000;
    do_reset();
    pulse_start();
    step(); step();
    chk("jmp_fetch_255", imem_addr, 8'd255);
    step();
    chk("jmp_pc_wrap", pc_out, 8'd0);
    step();
    chk("jmp_pc_target", pc_out, 8'd5);
    for (int c = 0; c < 20 && !halted; c++) step();
    chk("jmp_halted", halted, 1);
    chk("jmp_retired", retired, 16'd2);
    for (int c = 0; c < 6; c++) begin
      start = c[0];
      step();
      chk("halt_state", state_out, 3'd6);
      chk("halt_retired", retired, 16'd2);
      chk("halt_no_req", {imem_req, dmem_req, rf_we}, 3'b0);
    end
    start = 0;

    // Reset while MEM is waiting on a withheld ack.
    fill_hlt(); imem[0] = 16'h0000; imem_dly = 0; dmem_dly = 1000;
    do_reset();
    pulse_start();
    for (int c = 0; c < 20 && state_out != 3'd4; c++) step();
    chk("mem_reached", state_out, 3'd4);
    step(); step();
    chk("mem_still_req", {dmem_req, dmem_we}, 2'b10);
    rst_n = 0;
    step();
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_state", state_out, 3'd0);
    chk("rst_pc", pc_out, 8'd0);
    chk("rst_rf_we", rf_we, 0);
    rst_n = 1;
    step();
    chk("rst_after_rf_we", rf_we, 0);
    chk("rst_after_state", state_out, 3'd0);
    dmem_dly = 0;

    // Randomised program, random ack delays and spurious acks.
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
      imem[i] = w;
    end
    rnd_mode = 1;
    do_reset();
    pulse_start();
    repeat (3000) step();
    chk("rnd_not_halted", halted, 0);
    chk("rnd_progress", retired > 16'd100, 1);
    rnd_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
